// File: rtl/conv_tag_pkg.sv
// Shared definitions for the column tag chain: tag width helper, idle tag
// value and the result record used at the retirement end.
package conv_tag_pkg;

  // Tag width for a given column count; the extra bit leaves room for
  // out-of-range values so they can be detected rather than aliased.
  function automatic int TAG_W(input int num_col);
    return $clog2(num_col) + 1;
  endfunction

  localparam int TAG_IDLE = 0;

  // Result record for the default configuration (NUM_COL=8, DATA_W=32).
  typedef struct packed {
    logic        [3:0]  tag;
    logic signed [31:0] data;
  } tag_result_t;

endpackage

// File: rtl/tag_collect_if.sv
// Beat input and result output streams of tag_collect, both valid/ready.
interface tag_collect_if #(
  parameter int TAG_BITS = 4,
  parameter int DATA_W   = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [TAG_BITS-1:0]      in_tag;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [TAG_BITS-1:0]      out_tag;
  logic signed [DATA_W-1:0] out_data;

  // Producer of beats / consumer of results.
  modport master (
    output in_valid, in_tag, in_data, out_ready,
    input  in_ready, out_valid, out_tag, out_data
  );

  // The collector itself.
  modport slave (
    input  in_valid, in_tag, in_data, out_ready,
    output in_ready, out_valid, out_tag, out_data
  );
endinterface

// File: rtl/tag_result_fifo.sv
// Synchronous first-word-fall-through FIFO for finished tag results.
// dout reads as 0 while the FIFO is empty.
module tag_result_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_cnt == (AW+1)'(DEPTH));
  assign empty     = (r_cnt == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = empty ? '0 : r_mem[r_rd];

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/tag_collect.sv
// Retirement end of the column tag chain: accumulates tagged partial sums per
// tag, queues finished sums in a FWFT FIFO and pulses the retired tag back to
// the allocator.
// Build option: define TAG_COLLECT_SAT_EN to saturate accumulation to the
// signed DATA_W range; otherwise accumulation wraps (two's complement).
module tag_collect
  import conv_tag_pkg::*;
#(
  parameter  int NUM_COL    = 8,
  parameter  int DATA_W     = 32,
  parameter  int CNT_W      = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int TAG_BITS   = TAG_W(NUM_COL)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clear,
  input  logic [CNT_W-1:0]    beats_per_tag,
  tag_collect_if.slave        bus,
  output logic                free_valid,
  output logic [TAG_BITS-1:0] free_tag,
  output logic                err
);

  // Adds one beat to an accumulator, saturating or wrapping per build option.
  function automatic logic signed [DATA_W-1:0] acc_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
`ifdef TAG_COLLECT_SAT_EN
    logic signed [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return s[DATA_W-1:0];
`else
    return a + b;
`endif
  endfunction

  logic signed [DATA_W-1:0] r_acc [NUM_COL];
  logic [CNT_W-1:0]         r_cnt [NUM_COL];

  logic                     w_full;
  logic                     w_empty;
  logic                     w_fire;
  logic                     w_legal;
  logic                     w_oor;
  logic [NUM_COL-1:0]       w_hit;
  logic signed [DATA_W-1:0] w_acc_sel;
  logic [CNT_W-1:0]         w_cnt_sel;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic [CNT_W-1:0]         w_target;
  logic signed [DATA_W-1:0] w_sum;
  logic                     w_done;
  logic                     w_pop;
  logic [TAG_BITS+DATA_W-1:0] w_fifo_dout;

  assign bus.in_ready = rstn && !w_full;
  assign w_fire       = bus.in_valid && bus.in_ready && !clear;
  assign w_legal      = (bus.in_tag != TAG_BITS'(TAG_IDLE)) && (bus.in_tag <= TAG_BITS'(NUM_COL));
  assign w_oor        = bus.in_tag > TAG_BITS'(NUM_COL);
  assign w_target     = (beats_per_tag == '0) ? CNT_W'(1) : beats_per_tag;
  assign w_cnt_nxt    = w_cnt_sel + CNT_W'(1);
  assign w_sum        = acc_add(w_acc_sel, bus.in_data);
  assign w_done       = w_fire && w_legal && (w_cnt_nxt == w_target);
  assign w_pop        = bus.out_valid && bus.out_ready;

  // Decode the beat's tag to a column slot and fetch its running sum and count.
  always_comb begin
    w_hit     = '0;
    w_acc_sel = '0;
    w_cnt_sel = '0;
    for (int i = 0; i < NUM_COL; i++) begin
      if (w_legal && (bus.in_tag == TAG_BITS'(i + 1))) begin
        w_hit[i]  = 1'b1;
        w_acc_sel = r_acc[i];
        w_cnt_sel = r_cnt[i];
      end
    end
  end

  // Per-tag accumulate; a completing beat returns its slot to zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_COL; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < NUM_COL; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_COL; i++) begin
        if (w_fire && w_hit[i]) begin
          r_acc[i] <= w_done ? '0 : w_sum;
          r_cnt[i] <= w_done ? '0 : w_cnt_nxt;
        end
      end
    end
  end

  // Retire pulse to the allocator and sticky out-of-range flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      free_valid <= 1'b0;
      free_tag   <= '0;
      err        <= 1'b0;
    end else if (clear) begin
      free_valid <= 1'b0;
      free_tag   <= '0;
      err        <= 1'b0;
    end else begin
      free_valid <= w_done;
      free_tag   <= w_done ? bus.in_tag : '0;
      if (w_fire && w_oor) err <= 1'b1;
    end
  end

  tag_result_fifo #(
    .WIDTH (TAG_BITS + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear),
    .push  (w_done),
    .din   ({bus.in_tag, w_sum}),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign bus.out_valid = !w_empty;
  assign bus.out_tag   = w_fifo_dout[DATA_W +: TAG_BITS];
  assign bus.out_data  = w_fifo_dout[DATA_W-1:0];

endmodule

// File: tb/tb_tag_collect.sv
// Directed bench for tag_collect: single-beat vector table plus hand-written
// multi-cycle sequences (accumulation, interleave, FIFO backpressure, clear,
// async reset, overflow behaviour).
module tb_tag_collect;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] beats_per_tag = 8'd1;
  logic       free_valid;
  logic [3:0] free_tag;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  tag_collect_if #(.TAG_BITS(4), .DATA_W(32)) bus ();

  tag_collect dut (
    .clk           (clk),
    .rstn          (rstn),
    .clear         (clear),
    .beats_per_tag (beats_per_tag),
    .bus           (bus),
    .free_valid    (free_valid),
    .free_tag      (free_tag),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    bit          exp_vld;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [3:0] t, input logic [31:0] d);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_tag   = t;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sat_a;
    logic [31:0] sat_b;
    int          nexp;
    bit          drop;

    bus.in_valid  = 1'b0;
    bus.in_tag    = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    vecs[0] = '{4'd1,  32'd5,         1'b1, 32'd5,         1'b0};
    vecs[1] = '{4'd8,  32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFD, 1'b0};
    vecs[2] = '{4'd0,  32'd9,         1'b0, 32'd0,         1'b0};
    vecs[3] = '{4'd3,  32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b0};
    vecs[4] = '{4'd9,  32'd1,         1'b0, 32'd0,         1'b1};
    vecs[5] = '{4'd5,  32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1};
    vecs[6] = '{4'd15, 32'd2,         1'b0, 32'd0,         1'b1};
    vecs[7] = '{4'd7,  32'd42,        1'b1, 32'd42,        1'b1};

    // reset state
    #12;
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_free",      {31'd0, free_valid},    32'd0);
    chk("rst_err",       {31'd0, err},           32'd0);
    chk("rst_out_data",  bus.out_data,           32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // single-beat table, beats_per_tag = 1
    beats_per_tag = 8'd1;
    for (int i = 0; i < 8; i++) begin
      beat(vecs[i].tag, vecs[i].data);
      chk($sformatf("v%0d_free_valid", i), {31'd0, free_valid},    {31'd0, vecs[i].exp_vld});
      chk($sformatf("v%0d_free_tag", i),   {28'd0, free_tag},      vecs[i].exp_vld ? {28'd0, vecs[i].tag} : 32'd0);
      chk($sformatf("v%0d_out_valid", i),  {31'd0, bus.out_valid}, {31'd0, vecs[i].exp_vld});
      chk($sformatf("v%0d_out_tag", i),    {28'd0, bus.out_tag},   vecs[i].exp_vld ? {28'd0, vecs[i].tag} : 32'd0);
      chk($sformatf("v%0d_out_data", i),   bus.out_data,           vecs[i].exp_data);
      chk($sformatf("v%0d_err", i),        {31'd0, err},           {31'd0, vecs[i].exp_err});
      idle_cycle();
    end

    // clear wins over a simultaneous beat and clears err
    @(negedge clk);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_tag   = 4'd1;
    bus.in_data  = 32'd11;
    @(posedge clk);
    #1;
    chk("clr_err",       {31'd0, err},           32'd0);
    chk("clr_free",      {31'd0, free_valid},    32'd0);
    chk("clr_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    clear        = 1'b0;
    bus.in_valid = 1'b0;

    // three beats on tag 1: 5 + 7 - 2 = 10
    beats_per_tag = 8'd3;
    beat(4'd1, 32'd5);
    chk("acc3_b1_free", {31'd0, free_valid}, 32'd0);
    beat(4'd1, 32'd7);
    chk("acc3_b2_out_valid", {31'd0, bus.out_valid}, 32'd0);
    beat(4'd1, 32'hFFFF_FFFE);
    chk("acc3_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("acc3_out_tag",   {28'd0, bus.out_tag},   32'd1);
    chk("acc3_out_data",  bus.out_data,           32'd10);
    chk("acc3_free",      {31'd0, free_valid},    32'd1);
    chk("acc3_free_tag",  {28'd0, free_tag},      32'd1);
    idle_cycle();
    chk("acc3_free_pulse", {31'd0, free_valid},    32'd0);
    chk("acc3_popped",     {31'd0, bus.out_valid}, 32'd0);

    // interleaved tags 2 and 3 with the output stalled
    beats_per_tag = 8'd2;
    bus.out_ready = 1'b0;
    beat(4'd2, 32'd1);
    beat(4'd3, 32'd10);
    beat(4'd2, 32'd2);
    chk("il_free_tag2", {28'd0, free_tag}, 32'd2);
    beat(4'd3, 32'd20);
    chk("il_free_tag3", {28'd0, free_tag}, 32'd3);
    idle_cycle();
    chk("il_head_tag",  {28'd0, bus.out_tag}, 32'd2);
    chk("il_head_data", bus.out_data,         32'd3);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("il_2nd_tag",  {28'd0, bus.out_tag}, 32'd3);
    chk("il_2nd_data", bus.out_data,         32'd30);
    @(posedge clk);
    #1;
    chk("il_drained", {31'd0, bus.out_valid}, 32'd0);

    // FIFO backpressure: four completions fill it, fifth beat is held
    beats_per_tag = 8'd1;
    bus.out_ready = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      beat(4'(t), 32'(10 * t));
      chk($sformatf("fill%0d_free_tag", t), {28'd0, free_tag}, 32'(t));
    end
    chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("full_head_tag", {28'd0, bus.out_tag},  32'd1);
    @(negedge clk);
    bus.in_tag  = 4'd5;
    bus.in_data = 32'd50;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("held%0d_in_ready", k), {31'd0, bus.in_ready}, 32'd0);
      chk($sformatf("held%0d_free", k),     {31'd0, free_valid},   32'd0);
    end
    bus.out_ready = 1'b1;
    nexp = 1;
    drop = 1'b0;
    for (int cyc = 0; cyc < 20 && nexp <= 5; cyc++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) drop = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("pop%0d_tag", nexp),  {28'd0, bus.out_tag}, 32'(nexp));
        chk($sformatf("pop%0d_data", nexp), bus.out_data,         32'(10 * nexp));
        nexp++;
      end
      @(posedge clk);
      #1;
      if (drop) begin
        bus.in_valid = 1'b0;
        drop = 1'b0;
      end
    end
    chk("drain_count", 32'(nexp), 32'd6);
    bus.in_valid = 1'b0;

    // async reset mid-accumulation discards the partial sum on tag 4
    beats_per_tag = 8'd3;
    beat(4'd4, 32'd100);
    beat(4'd4, 32'd200);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("mrst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mrst_free",      {31'd0, free_valid},    32'd0);
    chk("mrst_free_tag",  {28'd0, free_tag},      32'd0);
    chk("mrst_err",       {31'd0, err},           32'd0);
    chk("mrst_out_tag",   {28'd0, bus.out_tag},   32'd0);
    chk("mrst_out_data",  bus.out_data,           32'd0);
    @(negedge clk);
    rstn = 1'b1;
    beat(4'd4, 32'd1);
    beat(4'd4, 32'd1);
    beat(4'd4, 32'd1);
    chk("mrst_fresh_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("mrst_fresh_data",  bus.out_data,           32'd3);
    idle_cycle();

    // overflow at both ends of the signed range
    beats_per_tag = 8'd2;
`ifdef TAG_COLLECT_SAT_EN
    sat_a = 32'h7FFF_FFFF;
    sat_b = 32'h8000_0000;
`else
    sat_a = 32'h8000_0010;
    sat_b = 32'h7FFF_FFFF;
`endif
    beat(4'd6, 32'h7FFF_FFF0);
    beat(4'd6, 32'h0000_0020);
    chk("ovf_pos_data", bus.out_data, sat_a);
    idle_cycle();
    beat(4'd7, 32'h8000_0000);
    beat(4'd7, 32'hFFFF_FFFF);
    chk("ovf_neg_data", bus.out_data, sat_b);
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tag_collect.md
Name: tag_collect

Overview:
- Retirement end of the column tag chain in the convolution accelerator.
- Consumes tagged partial sums leaving the last PE column and accumulates them per tag.
- When a tag has received its configured number of beats, emits the finished sum on a valid/ready output stream through a small FIFO.
- Returns the tag ID to the allocator side as a one-cycle free pulse.

Parameters:
- NUM_COL, 8, number of columns; legal tag values are 1..NUM_COL, and 0 means idle.
- DATA_W, 32, width of partial sums and results.
- CNT_W, 8, width of the per-tag beat counter and of beats_per_tag.
- FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of all accumulators, counters, FIFO and err.
- beats_per_tag  in  CNT_W  beats per tag before completion; 0 is treated as 1.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when high together with in_valid.
- in_tag  in  $clog2(NUM_COL)+1  tag of the beat; same width as the allocator tag (extended by 1 bit).
- in_data  in  DATA_W  partial sum, two's complement.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_tag  out  $clog2(NUM_COL)+1  tag of the result.
- out_data  out  DATA_W  accumulated result.
- free_valid  out  1  one-cycle pulse: tag retired.
- free_tag  out  $clog2(NUM_COL)+1  retired tag ID.
- err  out  1  sticky: an out-of-range tag was received.

Behaviour:
- Reset (rstn low, asynchronous): all accumulators and counters are 0, the FIFO is empty, and out_valid, free_valid, free_tag, err, out_tag and out_data are all 0. in_ready is 0 during reset.
- A beat is accepted when in_valid && in_ready. in_ready = !fifo_full, using the registered occupancy.
- A beat with in_tag == 0 is consumed with no effect.
- A beat with in_tag > NUM_COL is consumed, err is set (sticky until clear or reset), and there is no other effect.
- For a legal tag t: acc[t] <= acc[t] + in_data, wrapping modulo 2^DATA_W, and cnt[t] <= cnt[t] + 1.
- Completion: when the accepted beat makes cnt[t]+1 == max(beats_per_tag,1):
  - On the next edge, {t, acc[t]+in_data} is pushed into the FIFO, and acc[t] and cnt[t] return to 0.
  - free_valid pulses in that same cycle N+1, with free_tag = t.
- Latency: a completing beat at edge N produces out_valid at N+1 if the FIFO was empty; the FIFO is first-word-fall-through.
- Output handshake:
  - out_valid stays high and out_tag/out_data stay stable until out_ready is sampled high.
  - A pop occurs when out_valid && out_ready.
- Simultaneous push and pop on a full FIFO: cannot occur, because in_ready is low when full. Push and pop in the same cycle otherwise leave the occupancy unchanged.
- Back-to-back beats on different tags are accepted every cycle. Back-to-back beats on the same tag must be accumulated correctly; read-after-write needs no bubble.
- beats_per_tag may change only while all cnt are 0. Behaviour otherwise is undefined.
- clear has priority over an input beat in the same cycle. The beat is dropped and in_ready is ignored.
- Reset mid-operation discards all partial sums and queued results; no free pulse is generated.

Optional Feature:
- Macro: TAG_COLLECT_SAT_EN.
- Defined: accumulation saturates to the signed DATA_W range, with max 2^(DATA_W-1)-1 and min -2^(DATA_W-1). Saturation is applied at every beat.
- Undefined: two's-complement wrap-around.

Decomposition:
- Shared package conv_tag_pkg:
  - localparam function TAG_W(NUM_COL) = $clog2(NUM_COL)+1.
  - Constant TAG_IDLE = 0.
  - Typedef of the result record {tag, data}.
- One natural sub-module: tag_result_fifo, a synchronous FWFT FIFO with parameters width and depth, ports push/pop/full/empty, and the same clk/rstn.

Test Plan:
- beats_per_tag=3; tag 1 beats 5, 7, -2 back to back with out_ready=1 -> one cycle after the third beat, out_valid=1 with out_tag=1, out_data=10, and free_valid pulses with free_tag=1.
- beats_per_tag=2; interleaved tag 2 beats (1,2) and tag 3 beats (10,20) -> results in completion order: tag 2 data 3, then tag 3 data 30.
- FIFO_DEPTH=4, out_ready=0, beats_per_tag=1, tags 1..5 in consecutive cycles:
  - in_ready drops after the 4th completion, and the 5th beat is held.
  - Raising out_ready pops 1, 2, 3, 4 in order, then tag 5.
- in_tag=0 and in_tag=NUM_COL+1 beats -> no output, no free pulse. err=1 after the out-of-range beat, and clear returns err to 0.
- Tag 4 partially accumulated (2 of 3 beats), then rstn pulsed low -> all outputs 0. A following 3 beats of 1 on tag 4 yield 3, not the stale sum.
- With TAG_COLLECT_SAT_EN, DATA_W=8, beats_per_tag=2, beats 100 and 100 -> out_data=127. Without the macro -> out_data=-56.
